instr_ctrl: RTL and testbench

Instruction register plus Moore control FSM that sits directly upstream of `datapath`. It latches a 16-bit instruction, decodes it, and sequences the datapath strobes (`readnum`, `loada`/`loadb`, `loadc`/`loads`, `write`, …) over multiple cycles. It also supplies the sign-extended immediate on `datapath_in`. Together with `datapath`, it forms a minimal multicycle CPU.

---
 rtl/cpu_pkg.sv | 89 ++++++++
 rtl/instr_ctrl_if.sv | 39 +++
 rtl/instr_dec.sv | 30 +++
 rtl/instr_ctrl.sv | 138 +++++++++++++
 tb/tb_instr_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the instruction controller: field positions, opcode
// constants, FSM state type, decoded instruction class and control payload.
package cpu_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned REG_SEL_W = 3;
    localparam int unsigned OPC_W     = 3;
    localparam int unsigned OP_W      = 2;
    localparam int unsigned SH_W      = 2;
    localparam int unsigned IMM_W     = 8;

    // Field least-significant bit positions inside the instruction word
    localparam int unsigned OPC_LSB = 13;
    localparam int unsigned OP_LSB  = 11;
    localparam int unsigned RN_LSB  = 8;
    localparam int unsigned RD_LSB  = 5;
    localparam int unsigned SH_LSB  = 3;
    localparam int unsigned RM_LSB  = 0;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
    localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

    localparam logic [OP_W-1:0] OP_MOVI = 2'b10;
    localparam logic [OP_W-1:0] OP_MOVR = 2'b00;
    localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
    localparam logic [OP_W-1:0] OP_CMP  = 2'b01;
    localparam logic [OP_W-1:0] OP_AND  = 2'b10;
    localparam logic [OP_W-1:0] OP_MVN  = 2'b11;

    localparam logic [OP_W-1:0] ALU_ADD = 2'b00;

    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        WRITE_IMM,
        GET_A,
        GET_B,
        EXEC,
        WRITE_RD
    } ctrl_state_t;

    typedef enum logic [2:0] {
        I_NOP,
        I_MOVI,
        I_MOVR,
        I_ADD,
        I_CMP,
        I_AND,
        I_MVN
    } instr_kind_t;

    // Registered control bundle driven toward the datapath
    typedef struct packed {
        logic                 w;
        logic [REG_SEL_W-1:0] readnum;
        logic [REG_SEL_W-1:0] writenum;
        logic                 vsel;
        logic                 asel;
        logic                 bsel;
        logic                 loada;
        logic                 loadb;
        logic                 loadc;
        logic                 loads;
        logic                 write;
        logic [SH_W-1:0]      shift;
        logic [OP_W-1:0]      alu_op;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_IDLE = '{w: 1'b1, default: '0};

    // Map opcode/op to an instruction class; anything unlisted is a no-op
    function automatic instr_kind_t classify(input logic [OPC_W-1:0] opcode,
                                             input logic [OP_W-1:0]  op);
        instr_kind_t kind;
        kind = I_NOP;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOVI)      kind = I_MOVI;
            else if (op == OP_MOVR) kind = I_MOVR;
        end else if (opcode == OPC_ALU) begin
            if (op == OP_ADD)       kind = I_ADD;
            else if (op == OP_CMP)  kind = I_CMP;
            else if (op == OP_AND)  kind = I_AND;
            else                    kind = I_MVN;
        end
        return kind;
    endfunction

endpackage

// File: rtl/instr_ctrl_if.sv
// Handshake and datapath control bundle between the instruction source, the
// controller and the datapath.
//   s, load, in     : start, IR load enable, instruction word (to controller)
//   w               : controller idle / ready for the next instruction
//   readnum..ALUop  : datapath selects and strobes
//   datapath_in     : sign-extended immediate from the IR
interface instr_ctrl_if;

    logic                              s;
    logic                              load;
    logic [cpu_pkg::INSTR_W-1:0]       in;
    logic                              w;
    logic [cpu_pkg::REG_SEL_W-1:0]     readnum;
    logic [cpu_pkg::REG_SEL_W-1:0]     writenum;
    logic                              vsel;
    logic                              asel;
    logic                              bsel;
    logic                              loada;
    logic                              loadb;
    logic                              loadc;
    logic                              loads;
    logic                              write;
    logic [cpu_pkg::SH_W-1:0]          shift;
    logic [cpu_pkg::OP_W-1:0]          ALUop;
    logic [cpu_pkg::INSTR_W-1:0]       datapath_in;

    modport master (
        output s, load, in,
        input  w, readnum, writenum, vsel, asel, bsel,
        input  loada, loadb, loadc, loads, write, shift, ALUop, datapath_in
    );

    modport slave (
        input  s, load, in,
        output w, readnum, writenum, vsel, asel, bsel,
        output loada, loadb, loadc, loads, write, shift, ALUop, datapath_in
    );

endinterface

// File: rtl/instr_dec.sv
// Combinational field extraction and immediate sign-extension from the IR.
//   ir                  : instruction register contents
//   opcode, op          : instruction class fields
//   rn, rd, rm, sh      : register selects and shift code
//   sximm8              : imm8 sign-extended to the datapath width
module instr_dec
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0]   ir,
    output logic [OPC_W-1:0]     opcode,
    output logic [OP_W-1:0]      op,
    output logic [REG_SEL_W-1:0] rn,
    output logic [REG_SEL_W-1:0] rd,
    output logic [REG_SEL_W-1:0] rm,
    output logic [SH_W-1:0]      sh,
    output logic [INSTR_W-1:0]   sximm8
);

    logic [IMM_W-1:0] imm8;

    assign opcode = ir[OPC_LSB +: OPC_W];
    assign op     = ir[OP_LSB  +: OP_W];
    assign rn     = ir[RN_LSB  +: REG_SEL_W];
    assign rd     = ir[RD_LSB  +: REG_SEL_W];
    assign rm     = ir[RM_LSB  +: REG_SEL_W];
    assign sh     = ir[SH_LSB  +: SH_W];
    assign imm8   = ir[IMM_LSB +: IMM_W];
    assign sximm8 = {{(INSTR_W-IMM_W){imm8[IMM_W-1]}}, imm8};

endmodule

// File: rtl/instr_ctrl.sv
// Instruction register plus multicycle Moore control FSM for the datapath.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of instr_ctrl_if (s/load/in in, control out)
// Control outputs are registered from the next state, so each strobe is high
// for exactly the cycle its state is occupied; datapath_in follows the IR.
module instr_ctrl
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    instr_ctrl_if.slave  bus
);

    logic [INSTR_W-1:0]   ir_q;
    ctrl_state_t          state_q;
    ctrl_state_t          state_d;
    ctrl_out_t            out_q;
    ctrl_out_t            out_d;
    instr_kind_t          kind;

    logic [OPC_W-1:0]     opcode;
    logic [OP_W-1:0]      op;
    logic [REG_SEL_W-1:0] rn;
    logic [REG_SEL_W-1:0] rd;
    logic [REG_SEL_W-1:0] rm;
    logic [SH_W-1:0]      sh;
    logic [INSTR_W-1:0]   sximm8;

    instr_dec u_dec (
        .ir     (ir_q),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (sh),
        .sximm8 (sximm8)
    );

    assign kind = classify(opcode, op);

    // Instruction register: writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
        end else if (state_q == WAIT && bus.load) begin
            ir_q <= bus.in;
        end
    end

    // State and control output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT;
            out_q   <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT:      if (bus.s) state_d = DECODE;
            DECODE: begin
                case (kind)
                    I_MOVI:              state_d = WRITE_IMM;
                    I_ADD, I_CMP, I_AND: state_d = GET_A;
                    I_MOVR, I_MVN:       state_d = GET_B;
                    default:             state_d = WAIT;
                endcase
            end
            WRITE_IMM: state_d = WAIT;
            GET_A:     state_d = GET_B;
            GET_B:     state_d = EXEC;
            EXEC:      state_d = (kind == I_CMP) ? WAIT : WRITE_RD;
            WRITE_RD:  state_d = WAIT;
            default:   state_d = WAIT;
        endcase
    end

    // Control values for the state being entered; the IR is already stable
    // for every state that uses its fields (it only changes entering DECODE)
    always_comb begin
        out_d = '0;
        case (state_d)
            WAIT: out_d.w = 1'b1;
            WRITE_IMM: begin
                out_d.vsel     = 1'b1;
                out_d.writenum = rn;
                out_d.write    = 1'b1;
            end
            GET_A: begin
                out_d.readnum = rn;
                out_d.loada   = 1'b1;
            end
            GET_B: begin
                out_d.readnum = rm;
                out_d.loadb   = 1'b1;
            end
            EXEC: begin
                out_d.shift = sh;
                out_d.loadc = (kind != I_CMP);
                out_d.loads = 1'b1;
                // MOV reg reuses the adder with A forced to zero
                if (kind == I_MOVR) begin
                    out_d.alu_op = ALU_ADD;
                    out_d.asel   = 1'b1;
                end else begin
                    out_d.alu_op = op;
                end
            end
            WRITE_RD: begin
                out_d.writenum = rd;
                out_d.write    = 1'b1;
            end
            default: out_d = '0;
        endcase
    end

    assign bus.w           = out_q.w;
    assign bus.readnum     = out_q.readnum;
    assign bus.writenum    = out_q.writenum;
    assign bus.vsel        = out_q.vsel;
    assign bus.asel        = out_q.asel;
    assign bus.bsel        = out_q.bsel;
    assign bus.loada       = out_q.loada;
    assign bus.loadb       = out_q.loadb;
    assign bus.loadc       = out_q.loadc;
    assign bus.loads       = out_q.loads;
    assign bus.write       = out_q.write;
    assign bus.shift       = out_q.shift;
    assign bus.ALUop       = out_q.alu_op;
    assign bus.datapath_in = sximm8;

endmodule

// File: tb/tb_instr_ctrl.sv
// Scoreboard bench for instr_ctrl with a behavioural datapath and ISA model.
module tb_instr_ctrl;

    typedef struct packed {
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        vsel;
        logic        asel;
        logic        bsel;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        write;
        logic [1:0]  shift;
        logic [1:0]  alu;
        logic [15:0] dpin;
    } step_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_ctrl_if bus();

    instr_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    step_t       exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    step_t       mon_e;
    step_t       mon_a;

    logic [15:0] rf [8];
    logic [15:0] ref_rf [8];
    logic [15:0] ra, rb, rc;
    logic        z, ref_z;

    function automatic logic [15:0] sx(input logic [15:0] ins);
        return {{8{ins[7]}}, ins[7:0]};
    endfunction

    function automatic logic [15:0] shf(input logic [15:0] b, input logic [1:0] sh);
        case (sh)
            2'd1:    return {b[14:0], 1'b0};
            2'd2:    return {1'b0, b[15:1]};
            2'd3:    return {b[15], b[15:1]};
            default: return b;
        endcase
    endfunction

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return ~b;
        endcase
    endfunction

    function automatic step_t observe();
        step_t s;
        s.readnum  = bus.readnum;
        s.writenum = bus.writenum;
        s.vsel     = bus.vsel;
        s.asel     = bus.asel;
        s.bsel     = bus.bsel;
        s.loada    = bus.loada;
        s.loadb    = bus.loadb;
        s.loadc    = bus.loadc;
        s.loads    = bus.loads;
        s.write    = bus.write;
        s.shift    = bus.shift;
        s.alu      = bus.ALUop;
        s.dpin     = bus.datapath_in;
        return s;
    endfunction

    // Behavioural datapath reacting to the controller strobes
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.write) rf[bus.writenum] <= bus.vsel ? bus.datapath_in : rc;
            if (bus.loada) ra <= rf[bus.readnum];
            if (bus.loadb) rb <= rf[bus.readnum];
            if (bus.loadc) rc <= alu_f(bus.asel ? 16'h0 : ra, shf(rb, bus.shift), bus.ALUop);
            if (bus.loads) z  <= (alu_f(bus.asel ? 16'h0 : ra, shf(rb, bus.shift), bus.ALUop) == 16'h0);
        end
    end

    // Monitor: every busy cycle must match the next expected step
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            n_cmp++;
            mon_a = observe();
            if (!bus.w) begin
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_busy t=%0t act=%h required=idle", $time, mon_a);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_a !== mon_e) begin
                        n_bad++;
                        $display("FAIL step t=%0t act=%h required=%h", $time, mon_a, mon_e);
                    end
                end
            end else begin
                mon_a.dpin = 16'h0;
                if (mon_a !== '0) begin
                    n_bad++;
                    $display("FAIL idle_strobes t=%0t act=%h required=0", $time, mon_a);
                end
            end
        end
    end

    // ISA-level model: expected per-cycle controls, latency and register effects
    task automatic build(input logic [15:0] ins, output int lat);
        logic [2:0]  opc, rn, rd, rm;
        logic [1:0]  op, sh;
        logic [15:0] val;
        step_t       st;
        bit          is_mov, is_cmp, is_mvn;
        opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
        rd  = ins[7:5];   sh = ins[4:3];   rm = ins[2:0];
        st = '0;
        st.dpin = sx(ins);
        exp_q.push_back(st);                         // decode cycle
        if (opc == 3'b110 && op == 2'b10) begin
            lat = 2;
            st.vsel = 1'b1; st.writenum = rn; st.write = 1'b1;
            exp_q.push_back(st);
            ref_rf[rn] = sx(ins);
        end else if (opc == 3'b101 || (opc == 3'b110 && op == 2'b00)) begin
            is_mov = (opc == 3'b110);
            is_cmp = !is_mov && op == 2'b01;
            is_mvn = !is_mov && op == 2'b11;
            lat = (is_mov || is_mvn || is_cmp) ? 4 : 5;
            if (!is_mov && !is_mvn) begin
                st = '0; st.dpin = sx(ins); st.readnum = rn; st.loada = 1'b1;
                exp_q.push_back(st);
            end
            st = '0; st.dpin = sx(ins); st.readnum = rm; st.loadb = 1'b1;
            exp_q.push_back(st);
            st = '0; st.dpin = sx(ins); st.shift = sh; st.loads = 1'b1;
            st.loadc = !is_cmp; st.asel = is_mov; st.alu = is_mov ? 2'b00 : op;
            exp_q.push_back(st);
            if (!is_cmp) begin
                st = '0; st.dpin = sx(ins); st.writenum = rd; st.write = 1'b1;
                exp_q.push_back(st);
            end
            val = alu_f(is_mov ? 16'h0 : ref_rf[rn], shf(ref_rf[rm], sh), is_mov ? 2'b00 : op);
            ref_z = (val == 16'h0);
            if (!is_cmp) ref_rf[rd] = val;
        end else begin
            lat = 1;
        end
    endtask

    // Issue one instruction; optionally assert load with a junk word at cycle poke_at
    task automatic run(input logic [15:0] ins, input int poke_at);
        int  lat;
        int  cyc;
        bit  rf_ok;
        build(ins, lat);
        bus.in = ins; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk); #2;
        bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'($urandom);
        cyc = 0;
        while (!bus.w && cyc < 20) begin
            if (cyc == poke_at) begin
                bus.load = 1'b1; bus.in = 16'($urandom);
            end else begin
                bus.load = 1'b0;
            end
            @(posedge clk); #2;
            cyc++;
        end
        bus.load = 1'b0;
        n_cmp++;
        if (cyc != lat) begin
            n_bad++;
            $display("FAIL latency ins=%h act=%0d required=%0d", ins, cyc, lat);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_steps ins=%h act=%0d required=0", ins, exp_q.size());
            exp_q.delete();
        end
        rf_ok = 1'b1;
        for (int i = 0; i < 8; i++) if (rf[i] !== ref_rf[i]) rf_ok = 1'b0;
        n_cmp++;
        if (!rf_ok || z !== ref_z) begin
            n_bad++;
            $display("FAIL regfile ins=%h act=%h_%h_%h_%h z=%b required=%h_%h_%h_%h z=%b",
                     ins, rf[0], rf[1], rf[2], rf[3], z,
                     ref_rf[0], ref_rf[1], ref_rf[2], ref_rf[3], ref_z);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s act=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        logic [15:0] ins;
        int          k;
        bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'h0;
        for (int i = 0; i < 8; i++) begin
            rf[i] = 16'h0; ref_rf[i] = 16'h0;
        end
        ra = '0; rb = '0; rc = '0; z = 1'b0; ref_z = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        check("reset_w", 32'(bus.w), 32'd1);
        check("reset_ctrl", 32'(observe()), 32'd0);
        mon_en = 1'b1;

        // Directed program
        run(16'hD007, -1);                 // MOV R0,#7
        run(16'hD3FF, -1);                 // MOV R3,#-1
        run(16'hD102, -1);                 // MOV R1,#2
        run(16'hA148, 3);                  // ADD R2,R1,R0,LSL#1 with load poked in EXEC
        check("add_r2", 32'(rf[2]), 32'h0010);
        run(16'hA801, -1);                 // CMP R0,R1
        check("cmp_z", 32'(z), 32'd0);
        run(16'h0000, -1);                 // illegal

        // Reset pulsed during GET_B of an ADD
        mon_en = 1'b0;
        bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk); #2;
        bus.s = 1'b0; bus.load = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("getb_before_reset", {bus.readnum, bus.loadb}, {3'd0, 1'b1});
        rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", {15'(observe()), bus.w}, 32'd1);
        check("async_reset_dpin", 32'(bus.datapath_in), 32'd0);
        #2 rst_n = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("idle_after_reset", 32'(bus.w), 32'd1);

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 7));
            ins = 16'($urandom);
            case (k)
                0:       ins[15:11] = 5'b11010;
                1:       ins[15:11] = 5'b11000;
                2, 3, 4: ins[15:13] = 3'b101;
                5:       ins[15:11] = 5'b10111;
                6:       ins[15:11] = {3'b110, 1'b0, 1'b1};
                default: ins = ins;
            endcase
            run(ins, int'($urandom_range(0, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
